// File: rtl/eth_rst_pkg.sv
// Shared state encodings and default timing for the Ethernet PHY reset sequencer.
// Cycle counts assume the 25 MHz board oscillator.
package eth_rst_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_LOCK  = 3'd0,
    ST_PHY_RST    = 3'd1,
    ST_PHY_SETTLE = 3'd2,
    ST_RUN        = 3'd3
  } seq_state_e;

  localparam int unsigned DEF_LOCK_STABLE_CYCLES = 32'd1024;
  localparam int unsigned DEF_PHY_RST_CYCLES     = 32'd250_000;
  localparam int unsigned DEF_PHY_SETTLE_CYCLES  = 32'd1_250_000;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) begin
      m = b;
    end else begin
      m = m;
    end
    if (c > m) begin
      m = c;
    end else begin
      m = m;
    end
    return m;
  endfunction

  // Shared counter width: one spare bit above the largest cycle count.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    return $clog2(max3(a, b, c)) + 32'd1;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Two-flop synchronizer for a single asynchronous level; both flops reset to 0.
module sync_bit (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next values of the two-stage shift.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchronizer flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/eth_phy_rst_seq.sv
// Ethernet PHY reset sequencer: waits for stable PLL lock, pulses the PHY reset,
// lets the PHY settle, then releases the Ethernet core reset.
module eth_phy_rst_seq
  import eth_rst_pkg::*;
#(
  parameter int unsigned LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
  parameter int unsigned PHY_RST_CYCLES     = DEF_PHY_RST_CYCLES,
  parameter int unsigned PHY_SETTLE_CYCLES  = DEF_PHY_SETTLE_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       soft_rst_req,
  output logic       phy_rst_n,
  output logic       core_rst,
  output logic       ready,
  output logic [2:0] seq_state
);

  localparam int unsigned CNT_W =
    cnt_width(LOCK_STABLE_CYCLES, PHY_RST_CYCLES, PHY_SETTLE_CYCLES);

  // Terminal counts: the exit edge is the one that sees the last count value.
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_STABLE_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PHY_RST_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(PHY_SETTLE_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(32'd0);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(32'd1);

  logic             locked_s;
  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phy_rst_n_q, phy_rst_n_d;
  logic             core_rst_q, core_rst_d;
  logic             ready_q, ready_d;

  sync_bit u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  // Next-state and shared-counter logic; lock loss outranks a soft request.
  always_comb begin
    state_d = state_q;
    cnt_d   = CNT_ZERO;
    case (state_q)
      ST_WAIT_LOCK: begin
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == LOCK_LAST) begin
          state_d = ST_PHY_RST;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      ST_PHY_RST: begin
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == RST_LAST) begin
          state_d = ST_PHY_SETTLE;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ST_PHY_RST;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      ST_PHY_SETTLE: begin
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = CNT_ZERO;
        end else if (soft_rst_req) begin
          state_d = ST_PHY_RST;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == SETTLE_LAST) begin
          state_d = ST_RUN;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ST_PHY_SETTLE;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = CNT_ZERO;
        end else if (soft_rst_req) begin
          state_d = ST_PHY_RST;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ST_RUN;
          cnt_d   = CNT_ZERO;
        end
      end
      default: begin
        state_d = ST_WAIT_LOCK;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Outputs decode the next state so they change on the same edge as the state.
  always_comb begin
    phy_rst_n_d = 1'b0;
    core_rst_d  = 1'b1;
    ready_d     = 1'b0;
    case (state_d)
      ST_PHY_SETTLE: begin
        phy_rst_n_d = 1'b1;
        core_rst_d  = 1'b1;
        ready_d     = 1'b0;
      end
      ST_RUN: begin
        phy_rst_n_d = 1'b1;
        core_rst_d  = 1'b0;
        ready_d     = 1'b1;
      end
      default: begin
        phy_rst_n_d = 1'b0;
        core_rst_d  = 1'b1;
        ready_d     = 1'b0;
      end
    endcase
  end

  // Sequencer state, counter and output flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_WAIT_LOCK;
      cnt_q       <= CNT_ZERO;
      phy_rst_n_q <= 1'b0;
      core_rst_q  <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      phy_rst_n_q <= phy_rst_n_d;
      core_rst_q  <= core_rst_d;
      ready_q     <= ready_d;
    end
  end

  assign phy_rst_n = phy_rst_n_q;
  assign core_rst  = core_rst_q;
  assign ready     = ready_q;
  assign seq_state = state_q;

endmodule

// File: tb/tb_eth_phy_rst_seq.sv
// Directed scoreboard bench for eth_phy_rst_seq with short cycle counts (4/8/16).
module tb_eth_phy_rst_seq;

  logic       clk;
  logic       rst_n;
  logic       pll_locked;
  logic       soft_rst_req;
  logic       phy_rst_n;
  logic       core_rst;
  logic       ready;
  logic [2:0] seq_state;

  int checks;
  int errors;
  int edge_n;

  int         exp_at_q[$];
  string      exp_tag_q[$];
  logic [5:0] exp_val_q[$];

  eth_phy_rst_seq #(
    .LOCK_STABLE_CYCLES (4),
    .PHY_RST_CYCLES     (8),
    .PHY_SETTLE_CYCLES  (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pll_locked   (pll_locked),
    .soft_rst_req (soft_rst_req),
    .phy_rst_n    (phy_rst_n),
    .core_rst     (core_rst),
    .ready        (ready),
    .seq_state    (seq_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {seq_state, phy_rst_n, core_rst, ready} at a given edge number.
  task automatic push(input int at, input string tag, input logic [2:0] st,
                      input logic phy, input logic core, input logic rdy);
    exp_at_q.push_back(at);
    exp_tag_q.push_back(tag);
    exp_val_q.push_back({st, phy, core, rdy});
  endtask

  task automatic drain();
    string      tag;
    logic [5:0] exp;
    logic [5:0] obs;
    while (exp_at_q.size() > 0 && exp_at_q[0] == edge_n) begin
      void'(exp_at_q.pop_front());
      tag = exp_tag_q.pop_front();
      exp = exp_val_q.pop_front();
      obs = {seq_state, phy_rst_n, core_rst, ready};
      checks++;
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s: observed st/phy/core/rdy=%b expected=%b at edge %0d",
               tag, obs, exp, edge_n);
      end
    end
  endtask

  task automatic check_now(input string tag, input logic [2:0] st,
                           input logic phy, input logic core, input logic rdy);
    push(edge_n, tag, st, phy, core, rdy);
    drain();
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    #1;
    drain();
  endtask

  task automatic run_to(input int e);
    while (edge_n < e) tick();
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    edge_n       = 0;
    rst_n        = 1'b0;
    pll_locked   = 1'b0;
    soft_rst_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_now("rst_hold", 3'd0, 1'b0, 1'b1, 1'b0);

    // Clean start: lock present from the first edge after release.
    rst_n      = 1'b1;
    pll_locked = 1'b1;
    edge_n     = 0;
    push(5,  "cs_wait",   3'd0, 1'b0, 1'b1, 1'b0);
    push(6,  "cs_rst",    3'd1, 1'b0, 1'b1, 1'b0);
    push(13, "cs_rst_end",3'd1, 1'b0, 1'b1, 1'b0);
    push(14, "cs_settle", 3'd2, 1'b1, 1'b1, 1'b0);
    push(29, "cs_set_end",3'd2, 1'b1, 1'b1, 1'b0);
    push(30, "cs_run",    3'd3, 1'b1, 1'b0, 1'b1);
    push(32, "cs_hold",   3'd3, 1'b1, 1'b0, 1'b1);
    run_to(32);

    // Soft reset pulse in RUN.
    soft_rst_req = 1'b1;
    push(33, "sr_rst",    3'd1, 1'b0, 1'b1, 1'b0);
    push(40, "sr_rst_end",3'd1, 1'b0, 1'b1, 1'b0);
    push(41, "sr_settle", 3'd2, 1'b1, 1'b1, 1'b0);
    push(56, "sr_set_end",3'd2, 1'b1, 1'b1, 1'b0);
    push(57, "sr_run",    3'd3, 1'b1, 1'b0, 1'b1);
    tick();
    soft_rst_req = 1'b0;
    run_to(60);

    // Lock loss in RUN, then re-lock.
    pll_locked = 1'b0;
    push(62, "ll_hold",   3'd3, 1'b1, 1'b0, 1'b1);
    push(63, "ll_wait",   3'd0, 1'b0, 1'b1, 1'b0);
    run_to(64);
    pll_locked = 1'b1;
    push(69, "rl_wait",   3'd0, 1'b0, 1'b1, 1'b0);
    push(70, "rl_rst",    3'd1, 1'b0, 1'b1, 1'b0);
    push(78, "rl_settle", 3'd2, 1'b1, 1'b1, 1'b0);
    push(93, "rl_set_end",3'd2, 1'b1, 1'b1, 1'b0);
    push(94, "rl_run",    3'd3, 1'b1, 1'b0, 1'b1);
    run_to(96);

    // Lock loss with a simultaneous soft request, then lock chatter.
    pll_locked = 1'b0;
    push(98,  "ls_pre",    3'd3, 1'b1, 1'b0, 1'b1);
    push(99,  "ls_both",   3'd0, 1'b0, 1'b1, 1'b0);
    push(108, "ch_wait",   3'd0, 1'b0, 1'b1, 1'b0);
    push(111, "ch_wait2",  3'd0, 1'b0, 1'b1, 1'b0);
    push(112, "ch_rst",    3'd1, 1'b0, 1'b1, 1'b0);
    push(120, "ch_settle", 3'd2, 1'b1, 1'b1, 1'b0);
    push(135, "ch_set_end",3'd2, 1'b1, 1'b1, 1'b0);
    push(136, "ch_run",    3'd3, 1'b1, 1'b0, 1'b1);
    run_to(98);
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    run_to(102);
    pll_locked = 1'b1;
    run_to(105);
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    run_to(138);

    // Async reset while PHY_SETTLE has counted to 9.
    soft_rst_req = 1'b1;
    push(139, "ar_rst",    3'd1, 1'b0, 1'b1, 1'b0);
    push(146, "ar_rst_end",3'd1, 1'b0, 1'b1, 1'b0);
    push(147, "ar_settle", 3'd2, 1'b1, 1'b1, 1'b0);
    push(156, "ar_pre",    3'd2, 1'b1, 1'b1, 1'b0);
    tick();
    soft_rst_req = 1'b0;
    run_to(156);
    #2;
    rst_n = 1'b0;
    #1;
    check_now("ar_async", 3'd0, 1'b0, 1'b1, 1'b0);
    #2;
    rst_n  = 1'b1;
    edge_n = 0;
    push(5,  "ar2_wait",   3'd0, 1'b0, 1'b1, 1'b0);
    push(6,  "ar2_rst",    3'd1, 1'b0, 1'b1, 1'b0);
    push(13, "ar2_rst_end",3'd1, 1'b0, 1'b1, 1'b0);
    push(14, "ar2_settle", 3'd2, 1'b1, 1'b1, 1'b0);
    push(29, "ar2_set_end",3'd2, 1'b1, 1'b1, 1'b0);
    push(30, "ar2_run",    3'd3, 1'b1, 1'b0, 1'b1);
    run_to(32);

    checks++;
    assert (exp_at_q.size() === 0) else begin
      errors++;
      $error("FAIL sb_empty: observed %0d pending expectations, expected 0", exp_at_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
